r22sdf_seq_ctrl: RTL
====================

Name: r22sdf_seq_ctrl

Overview:
- Sequencer for a chain of R22SDF stages (butterfly plus twiddle-multiplier modules).
- Holds the pipeline idle until every stage's twiddle CORDIC reports ready, then generates the global pipeline enable from an upstream valid/ready source and a downstream ready.
- Tracks pipeline fill and flags output validity with start-of-frame/end-of-frame markers.
- Flushes the pipeline with zero samples on request.

Parameters:
- FFT_LENGTH, 64, transform size; power of 4, ≥ 4.
- N_STAGES, clog4(FFT_LENGTH), number of R22SDF stages.
- PIPE_LAT, FFT_LENGTH-1, number of enables between a sample entering and its result appearing on the chain output.
- IDX_W, clog2(FFT_LENGTH), width of the frame index counters.

Ports:
- sys_clk, in, 1, single clock.
- sys_rst, in, 1, reset.
- cordic_rdy_vec, in, N_STAGES, per-stage twiddle-ready flags.
- s_valid, in, 1, upstream sample valid.
- s_ready, out, 1, sample accepted this cycle when s_valid is also high.
- m_ready, in, 1, downstream can accept.
- m_valid, out, 1, chain output is a valid bin this cycle.
- m_sop, out, 1, output bin index 0.
- m_eop, out, 1, output bin index FFT_LENGTH-1.
- m_idx, out, IDX_W, output bin index (natural digit-reversed order as produced).
- sys_en_glb, out, 1, pipeline enable to all stages.
- tw_en, out, 1, twiddle address/CORDIC enable to all stages.
- zero_in, out, 1, datapath input mux selects zero.
- flush_req, in, 1, one-cycle request to drain the pipeline.
- busy, out, 1, high in any state except RUN-idle-empty.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - State = INIT.
  - All counters 0; primed = 0; flush_pend = 0.
  - s_ready, m_valid, m_sop, m_eop, sys_en_glb, zero_in = 0.
  - tw_en = 1.
- States:
  - INIT: tw_en = 1, sys_en_glb = 0. Go to RUN on the first cycle where every bit of cordic_rdy_vec is 1. A rdy bit dropping afterwards is ignored.
  - RUN:
    - s_ready = m_ready | ~primed.
    - fire = s_valid & s_ready.
    - sys_en_glb = tw_en = fire; zero_in = 0.
  - FLUSH:
    - zero_in = 1, s_ready = 0.
    - fire = m_ready | ~primed; sys_en_glb = tw_en = fire.
- Fill tracking:
  - fill_cnt increments on fire until it reaches PIPE_LAT, then saturates.
  - primed = (fill_cnt == PIPE_LAT), registered.
- Output flags:
  - m_valid = fire & primed, combinational in the same cycle as the enable (dout is presented before the edge).
  - m_sop = m_valid & (m_idx == 0).
  - m_eop = m_valid & (m_idx == FFT_LENGTH-1).
- Index counters:
  - in_idx advances on fire in RUN.
  - m_idx advances on m_valid.
  - Both wrap FFT_LENGTH-1 → 0.
- Flush:
  - flush_req sets flush_pend; the flag is sticky.
  - In RUN, leave for FLUSH when flush_pend & (in_idx == 0) & no fire this cycle. A request mid-frame is therefore deferred to the frame boundary.
  - In FLUSH, a down-counter is loaded with PIPE_LAT and decrements on fire.
  - When the counter reaches 0 with fire: next state RUN, fill_cnt = 0, primed = 0, flush_pend = 0.
  - When primed = 0 at entry (pipeline empty), FLUSH exits after 0 cycles; the transition goes RUN → RUN and clears flush_pend only.
- Stalls:
  - s_valid low or m_ready low with primed: no fire, and all counters hold.
  - SDF internal state holds because sys_en_glb = 0.
- Simultaneous events:
  - flush_req on the cycle in_idx wraps to 0: the request is honoured next cycle.
  - flush_req while in FLUSH: ignored.
- Reset mid-operation: returns to INIT within one cycle. The datapath contents are discarded (treated as garbage until primed again).
- busy = (state != RUN) | flush_pend | (fill_cnt != 0).

Decomposition:
- Package r22sdf_pkg holds:
  - the clog4/clog2 functions;
  - the state encoding (INIT = 2'd0, RUN = 2'd1, FLUSH = 2'd2);
  - the PIPE_LAT default derivation.
- Sub-module r22sdf_idx_cnt: a wrapping, enabled IDX_W counter with terminal-count output. Instantiated twice (in_idx, m_idx).
- Fill and flush counters stay inline.

Test Plan:
1. Reset, then cordic_rdy_vec = 4'b0111 for 20 cycles, then 4'b1111 → sys_en_glb = 0, tw_en = 1 throughout; s_ready rises the cycle after all bits are ready.
2. FFT_LENGTH = 64, s_valid and m_ready held high, 3 frames → first m_valid on the 64th fire; m_sop every 64 m_valid; m_eop at m_idx = 63; 192 inputs yield 129 outputs.
3. After primed, m_ready toggled 1-0-1-0 → sys_en_glb follows m_ready; s_ready = m_ready; m_idx advances only on high cycles.
4. s_valid gaps of 5 cycles mid-frame → counters frozen during gaps; output count equals input count minus 63.
5. flush_req at in_idx = 10 → FLUSH is entered at in_idx = 0 after 54 more fires; 63 zero_in fires occur, carrying the last frame's 63 pending outputs out; fill_cnt = 0 afterwards.
6. sys_rst asserted mid-frame (in_idx = 30) → next cycle state = INIT, m_valid = 0, all indices 0; the first output after re-prime has m_sop = 1.

Source files
------------

// File: rtl/r22sdf_pkg.sv
// r22sdf_pkg: shared helpers, state encoding and default latency for the R22SDF sequencer
package r22sdf_pkg;
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int clog4(input int n);
    return (clog2(n) + 1) / 2;
  endfunction
  function automatic int pipe_lat(input int n);
    return n - 1;
  endfunction
endpackage

// File: rtl/r22sdf_idx_cnt.sv
// r22sdf_idx_cnt: wrapping enabled frame index counter with terminal-count flag (clk, rst, en -> cnt, tc)
module r22sdf_idx_cnt
  import r22sdf_pkg::*;
#(
  parameter int LEN = 64,
  parameter int W   = clog2(LEN)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == W'(LEN - 1);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/r22sdf_seq_ctrl.sv
// r22sdf_seq_ctrl: gates the R22SDF chain on CORDIC readiness, drives the global enable from the source/sink handshake, tracks fill, frames outputs and flushes with zeros
module r22sdf_seq_ctrl
  import r22sdf_pkg::*;
#(
  parameter int FFT_LENGTH = 64,
  parameter int N_STAGES   = clog4(FFT_LENGTH),
  parameter int PIPE_LAT   = pipe_lat(FFT_LENGTH),
  parameter int IDX_W      = clog2(FFT_LENGTH)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_STAGES-1:0] cordic_rdy_vec,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                m_ready,
  output logic                m_valid,
  output logic                m_sop,
  output logic                m_eop,
  output logic [IDX_W-1:0]    m_idx,
  output logic                sys_en_glb,
  output logic                tw_en,
  output logic                zero_in,
  input  logic                flush_req,
  output logic                busy
);
  localparam int FW = clog2(PIPE_LAT + 1);
  state_t state, state_nxt;
  logic [FW-1:0] fill_cnt, flush_cnt;
  logic [IDX_W-1:0] in_idx;
  logic primed, flush_pend, fire, start_flush, end_flush, m_tc, in_tc_unused;
  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    fire        = 1'b0;
    zero_in     = 1'b0;
    start_flush = 1'b0;
    end_flush   = 1'b0;
    case (state)
      INIT: state_nxt = &cordic_rdy_vec ? RUN : INIT;
      RUN: begin
        s_ready     = m_ready | ~primed;
        fire        = s_valid & s_ready;
        start_flush = flush_pend & (in_idx == '0) & ~fire;
        // an empty pipeline has nothing to drain, so the flush collapses to RUN -> RUN
        state_nxt   = (start_flush & primed) ? FLUSH : RUN;
      end
      FLUSH: begin
        zero_in   = 1'b1;
        fire      = m_ready | ~primed;
        end_flush = fire & (flush_cnt == FW'(1));
        state_nxt = end_flush ? RUN : FLUSH;
      end
      default: state_nxt = INIT;
    endcase
  end
  assign sys_en_glb = fire;
  assign tw_en      = (state == INIT) | fire;
  assign m_valid    = fire & primed;
  assign m_sop      = m_valid & (m_idx == '0);
  assign m_eop      = m_valid & m_tc;
  assign busy       = (state != RUN) | flush_pend | (fill_cnt != '0);
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state      <= INIT;
      fill_cnt   <= '0;
      primed     <= 1'b0;
      flush_pend <= 1'b0;
      flush_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // primed mirrors fill_cnt == PIPE_LAT, so incrementing only while unprimed is the saturation
      if (end_flush) begin
        fill_cnt <= '0;
        primed   <= 1'b0;
      end else if (fire && !primed) begin
        fill_cnt <= fill_cnt + 1'b1;
        primed   <= fill_cnt == FW'(PIPE_LAT - 1);
      end
      if (end_flush || (start_flush && !primed)) flush_pend <= 1'b0;
      else if (flush_req && state != FLUSH) flush_pend <= 1'b1;
      if (start_flush) flush_cnt <= FW'(PIPE_LAT);
      else if (state == FLUSH && fire) flush_cnt <= flush_cnt - 1'b1;
    end
  r22sdf_idx_cnt #(.LEN(FFT_LENGTH), .W(IDX_W)) u_in_idx (
    .clk(sys_clk),
    .rst(sys_rst),
    .en (fire & (state == RUN)),
    .cnt(in_idx),
    .tc (in_tc_unused)
  );
  r22sdf_idx_cnt #(.LEN(FFT_LENGTH), .W(IDX_W)) u_m_idx (
    .clk(sys_clk),
    .rst(sys_rst),
    .en (m_valid),
    .cnt(m_idx),
    .tc (m_tc)
  );
endmodule
